// File: rtl/logic_exec_unit.sv
// logic_exec_unit
//   Two-stage execution unit for the RV32I bitwise logic instructions
//   (AND/OR/XOR and ANDI/ORI/XORI). A beat is decoded on entry and captured
//   in S1 (operation, operands, rd, illegal flag). The result is evaluated
//   between S1 and S2. S2 is the output register that drives every out_*
//   port. Both handshakes are valid/ready. in_ready depends combinationally
//   on out_ready, so a full pipeline can still take a new beat in the same
//   cycle that it hands one downstream.
//
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset
//   in_valid / in_ready   : input handshake
//   in_instr              : raw 32-bit instruction word
//   in_rs1, in_rs2        : operand values (in_rs2 is ignored for immediate forms)
//   out_valid / out_ready : output handshake
//   out_result            : logic result (zero for illegal instructions)
//   out_rd                : destination register, instr[11:7]
//   out_illegal           : instruction is not a supported logic operation
module logic_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } op_e;

    // An illegal beat carries a zero result, whatever the operation says.
    function automatic logic signed [XLEN-1:0] exec_logic(
        input op_e                     op,
        input logic signed [XLEN-1:0]  a,
        input logic signed [XLEN-1:0]  b,
        input logic                    ill
    );
        logic signed [XLEN-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        if (ill) begin
            r = '0;
        end
        return r;
    endfunction

    // ---- Stage p0: decode of the presented beat ----
    op_e                    op_p0;
    logic signed [XLEN-1:0] a_p0;
    logic signed [XLEN-1:0] b_p0;
    logic [4:0]             rd_p0;
    logic                   ill_p0;

    // The rs1/rs2 register-number fields are not needed: operand values arrive on ports.
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    always_comb begin
        op_p0  = OP_AND;
        ill_p0 = 1'b0;
        a_p0   = in_rs1;
        b_p0   = in_rs2;
        rd_p0  = in_instr[11:7];

        if (in_instr[6:0] == OPC_REG && in_instr[31:25] == 7'b0000000) begin
            b_p0 = in_rs2;
        end else if (in_instr[6:0] == OPC_IMM) begin
            b_p0 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end else begin
            ill_p0 = 1'b1;
        end

        case (in_instr[14:12])
            3'b111:  op_p0 = OP_AND;
            3'b110:  op_p0 = OP_OR;
            3'b100:  op_p0 = OP_XOR;
            default: ill_p0 = 1'b1;
        endcase
    end

    // ---- Stage p1: decoded operation register (S1) ----
    logic                   vld_p1;
    op_e                    op_p1;
    logic signed [XLEN-1:0] a_p1;
    logic signed [XLEN-1:0] b_p1;
    logic [4:0]             rd_p1;
    logic                   ill_p1;

    logic                   vld_p2;
    logic signed [XLEN-1:0] result_p2;
    logic [4:0]             rd_p2;
    logic                   ill_p2;

    logic ld_p1;
    logic ld_p2;

    // S2 is free when it is empty or is being drained this cycle.
    assign ld_p2    = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || ld_p2;
    assign ld_p1    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (ld_p1) begin
            vld_p1 <= 1'b1;
        end else if (ld_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            op_p1  <= op_p0;
            a_p1   <= a_p0;
            b_p1   <= b_p0;
            rd_p1  <= rd_p0;
            ill_p1 <= ill_p0;
        end
    end

    // ---- Stage p2: output register (S2) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            rd_p2     <= '0;
            ill_p2    <= 1'b0;
        end else begin
            if (ld_p2) begin
                vld_p2    <= 1'b1;
                result_p2 <= exec_logic(op_p1, a_p1, b_p1, ill_p1);
                rd_p2     <= rd_p1;
                ill_p2    <= ill_p1;
            end else if (out_ready) begin
                vld_p2    <= 1'b0;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_result  = result_p2;
    assign out_rd      = rd_p2;
    assign out_illegal = ill_p2;

endmodule
